// File: rtl/apb_exe_pkg.sv
// Shared types and register map for the APB path into the execution unit.
package apb_exe_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef logic [1:0] step_t;

  localparam step_t STEP_ARG_A  = 2'd0;
  localparam step_t STEP_ARG_B  = 2'd1;
  localparam step_t STEP_CTRL   = 2'd2;
  localparam step_t STEP_RESULT = 2'd3;

  localparam logic [7:0] ADDR_ARG_A  = 8'h00;
  localparam logic [7:0] ADDR_ARG_B  = 8'h04;
  localparam logic [7:0] ADDR_CTRL   = 8'h08;
  localparam logic [7:0] ADDR_RESULT = 8'h0C;

  localparam int CTRL_START_BIT = 7;

  // Opcode encoding must track the execution unit's decoder.
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_CMP = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } opcode_e;

endpackage

// File: rtl/apb_exe_requester.sv
// APB requester: turns one (argA, argB, op) command into four APB transfers to the exe unit.
// Optional ACCESS-phase timeout is compiled in with APB_REQ_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | ready for a command
// SETUP  | APB setup phase of the current step (psel=1, penable=0)
// ACCESS | APB access phase, waiting on pready (psel=1, penable=1)
// RESP   | holding result/error until the response is consumed
module apb_exe_requester
  import apb_exe_pkg::*;
#(
  parameter int BITS        = 4,
  parameter int OP_W        = 3,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [BITS-1:0]   i_argA,
  input  logic [BITS-1:0]   i_argB,
  input  logic [OP_W-1:0]   i_op,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [BITS-1:0]   o_result,
  output logic              o_rsp_err,
  output logic [ADDR_W-1:0] o_paddr,
  output logic              o_psel,
  output logic              o_penable,
  output logic              o_pwrite,
  output logic [DATA_W-1:0] o_pwdata,
  input  logic [DATA_W-1:0] i_prdata,
  input  logic              i_pready,
  input  logic              i_pslverr
);

  state_e           state;
  step_t            step;
  logic [BITS-1:0]  arg_a;
  logic [BITS-1:0]  arg_b;
  logic [OP_W-1:0]  op_q;

  // Only the low BITS of the result register carry data.
  logic unused_prdata_hi;
  assign unused_prdata_hi = ^i_prdata[DATA_W-1:BITS];

`ifdef APB_REQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  function automatic logic [ADDR_W-1:0] step_addr(input step_t s);
    case (s)
      STEP_ARG_A: step_addr = ADDR_W'(ADDR_ARG_A);
      STEP_ARG_B: step_addr = ADDR_W'(ADDR_ARG_B);
      STEP_CTRL:  step_addr = ADDR_W'(ADDR_CTRL);
      default:    step_addr = ADDR_W'(ADDR_RESULT);
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] step_wdata(input step_t s,
                                                   input logic [BITS-1:0] a,
                                                   input logic [BITS-1:0] b,
                                                   input logic [OP_W-1:0] op);
    logic [DATA_W-1:0] d;
    d = '0;
    case (s)
      STEP_ARG_A: d = {{(DATA_W-BITS){a[BITS-1]}}, a};
      STEP_ARG_B: d = {{(DATA_W-BITS){b[BITS-1]}}, b};
      STEP_CTRL: begin
        d[OP_W-1:0]      = op;
        d[CTRL_START_BIT] = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      step        <= STEP_ARG_A;
      arg_a       <= '0;
      arg_b       <= '0;
      op_q        <= '0;
      o_cmd_ready <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_result    <= '0;
      o_rsp_err   <= 1'b0;
      o_paddr     <= '0;
      o_psel      <= 1'b0;
      o_penable   <= 1'b0;
      o_pwrite    <= 1'b0;
      o_pwdata    <= '0;
`ifdef APB_REQ_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (i_cmd_valid && o_cmd_ready) begin
            arg_a       <= i_argA;
            arg_b       <= i_argB;
            op_q        <= i_op;
            step        <= STEP_ARG_A;
            o_cmd_ready <= 1'b0;
            o_psel      <= 1'b1;
            o_penable   <= 1'b0;
            o_pwrite    <= 1'b1;
            o_paddr     <= step_addr(STEP_ARG_A);
            o_pwdata    <= step_wdata(STEP_ARG_A, i_argA, i_argB, i_op);
            state       <= SETUP;
          end else begin
            o_cmd_ready <= 1'b1;
          end
        end

        SETUP: begin
          o_penable <= 1'b1;
`ifdef APB_REQ_TIMEOUT_EN
          tmo_cnt   <= TMO_W'(TIMEOUT_CYC - 1);
`endif
          state     <= ACCESS;
        end

        ACCESS: begin
          if (i_pready) begin
            if (i_pslverr || step == STEP_RESULT) begin
              o_result    <= i_pslverr ? '0 : i_prdata[BITS-1:0];
              o_rsp_err   <= i_pslverr;
              o_rsp_valid <= 1'b1;
              o_psel      <= 1'b0;
              o_penable   <= 1'b0;
              o_pwrite    <= 1'b0;
              o_paddr     <= '0;
              o_pwdata    <= '0;
              state       <= RESP;
            end else begin
              // psel stays high across back-to-back steps; only penable drops.
              step      <= step + 2'd1;
              o_penable <= 1'b0;
              o_pwrite  <= (step + 2'd1) != STEP_RESULT;
              o_paddr   <= step_addr(step + 2'd1);
              o_pwdata  <= step_wdata(step + 2'd1, arg_a, arg_b, op_q);
              state     <= SETUP;
            end
          end
`ifdef APB_REQ_TIMEOUT_EN
          else if (tmo_cnt == '0) begin
            o_result    <= '0;
            o_rsp_err   <= 1'b1;
            o_rsp_valid <= 1'b1;
            o_psel      <= 1'b0;
            o_penable   <= 1'b0;
            o_pwrite    <= 1'b0;
            o_paddr     <= '0;
            o_pwdata    <= '0;
            state       <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt - TMO_W'(1);
          end
`endif
        end

        RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_cmd_ready <= 1'b1;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_exe_requester.sv
// Directed bench for apb_exe_requester with a small behavioural APB slave.
module tb_apb_exe_requester;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [3:0]  i_argA, i_argB;
  logic [2:0]  i_op;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [3:0]  o_result;
  logic        o_rsp_err;
  logic [7:0]  o_paddr;
  logic        o_psel, o_penable, o_pwrite;
  logic [31:0] o_pwdata;
  logic [31:0] i_prdata;
  logic        i_pready;
  logic        i_pslverr;

  int n_cmp = 0;
  int n_bad = 0;

  // slave model controls
  int          wait_n = 0;
  int          wcnt = 0;
  logic        stuck = 1'b0;
  logic        err_en = 1'b0;
  logic [7:0]  err_addr = 8'h00;
  logic [31:0] rdata = 32'h0;

  // transfer log and stability tracking
  logic [7:0]  log_addr [8];
  logic        log_wr   [8];
  logic [31:0] log_data [8];
  int          n_xfer = 0;
  int          stab_err = 0;
  logic        in_wait = 1'b0;
  logic [7:0]  h_addr;
  logic [31:0] h_data;
  logic        h_wr;

  apb_exe_requester dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_argA(i_argA), .i_argB(i_argB), .i_op(i_op),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_result(o_result), .o_rsp_err(o_rsp_err),
    .o_paddr(o_paddr), .o_psel(o_psel), .o_penable(o_penable),
    .o_pwrite(o_pwrite), .o_pwdata(o_pwdata),
    .i_prdata(i_prdata), .i_pready(i_pready), .i_pslverr(i_pslverr)
  );

  always #5 i_clk = ~i_clk;

  assign i_pready  = o_psel & o_penable & (wcnt >= wait_n) & ~stuck;
  assign i_pslverr = i_pready & err_en & (o_paddr == err_addr);
  assign i_prdata  = rdata;

  always @(posedge i_clk) begin
    if (o_psel && o_penable && !i_pready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always @(negedge i_clk) begin
    if (i_rst_n && o_psel && o_penable) begin
      if (in_wait && (o_paddr !== h_addr || o_pwdata !== h_data || o_pwrite !== h_wr))
        stab_err++;
      in_wait = !i_pready;
      h_addr = o_paddr; h_data = o_pwdata; h_wr = o_pwrite;
      if (i_pready && n_xfer < 8) begin
        log_addr[n_xfer] = o_paddr;
        log_wr[n_xfer]   = o_pwrite;
        log_data[n_xfer] = o_pwdata;
        n_xfer++;
      end
    end else begin
      in_wait = 1'b0;
    end
  end

  // Issues a command from a negedge; lat = cycles from accept edge to first o_rsp_valid.
  task automatic run_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                         output int lat);
    int w;
    w = 0;
    while (!o_cmd_ready && w < 50) begin @(negedge i_clk); w++; end
    n_xfer = 0;
    i_cmd_valid = 1'b1; i_argA = a; i_argB = b; i_op = op;
    @(posedge i_clk);
    @(negedge i_clk);
    i_cmd_valid = 1'b0;
    lat = 1;
    while (!o_rsp_valid && lat < 200) begin @(negedge i_clk); lat++; end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_cmd_valid = 1'b0; i_rsp_ready = 1'b0;
    i_argA = '0; i_argB = '0; i_op = '0;
    repeat (2) @(negedge i_clk);
    n_cmp++; if (o_cmd_ready !== 1'b0) begin n_bad++; $display("FAIL reset_cmd_ready got %b want 0", o_cmd_ready); end
    n_cmp++; if ({o_psel, o_penable, o_pwrite, o_rsp_valid, o_rsp_err} !== 5'b0) begin n_bad++; $display("FAIL reset_ctl got %b want 00000", {o_psel, o_penable, o_pwrite, o_rsp_valid, o_rsp_err}); end
    n_cmp++; if (o_paddr !== 8'h0 || o_pwdata !== 32'h0 || o_result !== 4'h0) begin n_bad++; $display("FAIL reset_data got %h/%h/%h want 0/0/0", o_paddr, o_pwdata, o_result); end
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    n_cmp++; if (o_cmd_ready !== 1'b1) begin n_bad++; $display("FAIL idle_cmd_ready got %b want 1", o_cmd_ready); end
  endtask

  task automatic test_basic();
    int lat;
    wait_n = 0; rdata = 32'h1;
    run_cmd(4'd3, 4'hE, 3'd5, lat);
    n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL basic_latency got %0d want 9", lat); end
    n_cmp++; if (n_xfer !== 4) begin n_bad++; $display("FAIL basic_nxfer got %0d want 4", n_xfer); end
    n_cmp++; if (log_addr[0] !== 8'h00 || log_wr[0] !== 1'b1 || log_data[0] !== 32'h3) begin n_bad++; $display("FAIL basic_xfer0 got %h/%b/%h want 00/1/00000003", log_addr[0], log_wr[0], log_data[0]); end
    n_cmp++; if (log_addr[1] !== 8'h04 || log_wr[1] !== 1'b1 || log_data[1] !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL basic_xfer1 got %h/%b/%h want 04/1/fffffffe", log_addr[1], log_wr[1], log_data[1]); end
    n_cmp++; if (log_addr[2] !== 8'h08 || log_wr[2] !== 1'b1 || log_data[2] !== 32'h85) begin n_bad++; $display("FAIL basic_xfer2 got %h/%b/%h want 08/1/00000085", log_addr[2], log_wr[2], log_data[2]); end
    n_cmp++; if (log_addr[3] !== 8'h0C || log_wr[3] !== 1'b0 || log_data[3] !== 32'h0) begin n_bad++; $display("FAIL basic_xfer3 got %h/%b/%h want 0c/0/00000000", log_addr[3], log_wr[3], log_data[3]); end
    n_cmp++; if (o_result !== 4'h1 || o_rsp_err !== 1'b0 || o_psel !== 1'b0) begin n_bad++; $display("FAIL basic_rsp got %h/%b/%b want 1/0/0", o_result, o_rsp_err, o_psel); end
    i_rsp_ready = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    i_rsp_ready = 1'b0;
    n_cmp++; if (o_rsp_valid !== 1'b0 || o_cmd_ready !== 1'b1) begin n_bad++; $display("FAIL basic_handshake got valid=%b ready=%b want 0/1", o_rsp_valid, o_cmd_ready); end
  endtask

  task automatic test_wait_states();
    int lat;
    wait_n = 2; rdata = 32'h0000_000F; stab_err = 0;
    run_cmd(4'h8, 4'h7, 3'd0, lat);
    n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL wait_latency got %0d want 17", lat); end
    n_cmp++; if (stab_err !== 0) begin n_bad++; $display("FAIL wait_stable got %0d changes want 0", stab_err); end
    n_cmp++; if (log_data[0] !== 32'hFFFFFFF8 || log_data[1] !== 32'h7 || log_data[2] !== 32'h80) begin n_bad++; $display("FAIL wait_wdata got %h/%h/%h want fffffff8/00000007/00000080", log_data[0], log_data[1], log_data[2]); end
    n_cmp++; if (o_result !== 4'hF || o_rsp_err !== 1'b0) begin n_bad++; $display("FAIL wait_rsp got %h/%b want f/0", o_result, o_rsp_err); end
    i_rsp_ready = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    i_rsp_ready = 1'b0; wait_n = 0;
  endtask

  task automatic test_slverr();
    int lat;
    err_en = 1'b1; err_addr = 8'h04; rdata = 32'hA;
    run_cmd(4'd2, 4'd5, 3'd1, lat);
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL slverr_latency got %0d want 5", lat); end
    n_cmp++; if (n_xfer !== 2 || log_addr[1] !== 8'h04) begin n_bad++; $display("FAIL slverr_nxfer got %0d last %h want 2 last 04", n_xfer, log_addr[1]); end
    n_cmp++; if (o_result !== 4'h0 || o_rsp_err !== 1'b1) begin n_bad++; $display("FAIL slverr_rsp got %h/%b want 0/1", o_result, o_rsp_err); end
    i_rsp_ready = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    i_rsp_ready = 1'b0; err_en = 1'b0;
    repeat (3) @(negedge i_clk);
    n_cmp++; if (n_xfer !== 2) begin n_bad++; $display("FAIL slverr_no_more got %0d want 2", n_xfer); end
  endtask

  task automatic test_rsp_backpressure();
    int lat;
    int bad;
    rdata = 32'h6;
    run_cmd(4'd1, 4'd2, 3'd3, lat);
    i_cmd_valid = 1'b1; i_argA = 4'd1; i_argB = 4'd1; i_op = 3'd1;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (o_rsp_valid !== 1'b1 || o_result !== 4'h6 || o_cmd_ready !== 1'b0) bad++;
      @(negedge i_clk);
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
    n_cmp++; if (n_xfer !== 4) begin n_bad++; $display("FAIL bp_ignored got %0d xfers want 4", n_xfer); end
    i_rsp_ready = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    i_rsp_ready = 1'b0;
    n_cmp++; if (o_cmd_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after got %b want 1", o_cmd_ready); end
    n_xfer = 0; rdata = 32'h2;
    @(posedge i_clk); @(negedge i_clk);
    i_cmd_valid = 1'b0;
    lat = 1;
    while (!o_rsp_valid && lat < 200) begin @(negedge i_clk); lat++; end
    n_cmp++; if (lat !== 9 || log_data[0] !== 32'h1 || log_data[2] !== 32'h81) begin n_bad++; $display("FAIL bp_next_cmd got lat=%0d d0=%h d2=%h want 9/00000001/00000081", lat, log_data[0], log_data[2]); end
    i_rsp_ready = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    i_rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int w;
    int seen;
    int lat;
    wait_n = 3;
    w = 0;
    while (!o_cmd_ready && w < 50) begin @(negedge i_clk); w++; end
    i_cmd_valid = 1'b1; i_argA = 4'd4; i_argB = 4'd4; i_op = 3'd2;
    @(posedge i_clk); @(negedge i_clk);
    i_cmd_valid = 1'b0;
    w = 0;
    while (!(o_psel && o_penable && o_paddr == 8'h08) && w < 50) begin @(negedge i_clk); w++; end
    n_cmp++; if (w >= 50) begin n_bad++; $display("FAIL rstmid_reach got timeout want step2 access"); end
    i_rst_n = 1'b0;
    #1;
    n_cmp++; if ({o_psel, o_penable, o_pwrite, o_cmd_ready} !== 4'b0 || o_paddr !== 8'h0 || o_pwdata !== 32'h0) begin n_bad++; $display("FAIL rstmid_outputs got %b %h %h want 0000 00 00000000", {o_psel, o_penable, o_pwrite, o_cmd_ready}, o_paddr, o_pwdata); end
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1; wait_n = 0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge i_clk);
      if (o_rsp_valid) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rstmid_no_rsp got %0d want 0", seen); end
    rdata = 32'h9;
    run_cmd(4'd7, 4'd1, 3'd4, lat);
    n_cmp++; if (lat !== 9 || n_xfer !== 4 || o_result !== 4'h9) begin n_bad++; $display("FAIL rstmid_recover got lat=%0d n=%0d res=%h want 9/4/9", lat, n_xfer, o_result); end
    i_rsp_ready = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    i_rsp_ready = 1'b0;
  endtask

`ifdef APB_REQ_TIMEOUT_EN
  task automatic test_timeout();
    int lat;
    stuck = 1'b1; rdata = 32'h5;
    run_cmd(4'd1, 4'd1, 3'd0, lat);
    n_cmp++; if (lat !== 18) begin n_bad++; $display("FAIL timeout_latency got %0d want 18", lat); end
    n_cmp++; if (o_rsp_err !== 1'b1 || o_result !== 4'h0 || o_psel !== 1'b0 || o_penable !== 1'b0) begin n_bad++; $display("FAIL timeout_rsp got err=%b res=%h psel=%b pen=%b want 1/0/0/0", o_rsp_err, o_result, o_psel, o_penable); end
    stuck = 1'b0;
    i_rsp_ready = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    i_rsp_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_slverr();
    test_rsp_backpressure();
    test_reset_mid();
`ifdef APB_REQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
